// File: rtl/stream_write_scheduler_if.sv
// Distribution RAM write port: one write per cycle, accepted when
// mem_wready is high while mem_we is asserted.
interface stream_write_scheduler_if #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 16
);
    logic                     mem_we;
    logic                     mem_wready;
    logic [ADDRESS_WIDTH-2:0] mem_waddr;
    logic [3:0]               mem_wsel;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    modport master (
        output mem_we,
        output mem_waddr,
        output mem_wsel,
        output mem_wdata,
        input  mem_wready
    );

    modport slave (
        input  mem_we,
        input  mem_waddr,
        input  mem_wsel,
        input  mem_wdata,
        output mem_wready
    );
endinterface

// File: rtl/stream_write_scheduler.sv
// Streaming-pass sequencer for a D2Q9 lattice: walks cells in raster order,
// takes each cell's nine distributions and issues one RAM write per
// in-range direction, lowest direction first.
//
// state   | meaning
// IDLE    | waiting for start
// WAIT_IN | cell coordinate presented, waiting for f_in_valid
// WRITE   | issuing writes for the latched cell
// DONE    | one-cycle done pulse, then back to IDLE
module stream_write_scheduler #(
    parameter int GRID_DIM      = 256,
    parameter int SIDE_LENGTH   = GRID_DIM / 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDRESS_WIDTH-1:0]   cell_x,
    output logic [ADDRESS_WIDTH-1:0]   cell_y,
    input  logic [9*ADDRESS_WIDTH-1:0] stream_addr,
    input  logic [9*DATA_WIDTH-1:0]    f_in,
    input  logic                       f_in_valid,
    output logic                       f_in_ready,
    stream_write_scheduler_if.master   mem,
    output logic [15:0]                write_count
);

    typedef enum logic [1:0] {IDLE, WAIT_IN, WRITE, DONE} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_POS = ADDRESS_WIDTH'(SIDE_LENGTH - 1);

    state_t                   state;
    logic [8:0]               mask;
    logic [3:0]               cur_dir;
    logic [DATA_WIDTH-1:0]    f_q    [9];
    logic [ADDRESS_WIDTH-2:0] addr_q [9];

    logic [8:0] mask_in;
    logic [8:0] mask_rem;
    logic       cell_done;
    logic       last_cell;

    function automatic logic [3:0] lowest_set(input logic [8:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Direction-valid mask from the streaming unit and the mask left after the current write.
    always_comb begin
        mask_in = '0;
        for (int i = 0; i < 9; i++) begin
            mask_in[i] = ~stream_addr[(9-i)*ADDRESS_WIDTH-1];
        end
        mask_rem  = mask & ~(9'b1 << cur_dir);
        last_cell = (cell_x == LAST_POS) && (cell_y == LAST_POS);
        cell_done = ((state == WAIT_IN) && f_in_valid && (mask_in == 9'b0)) ||
                    ((state == WRITE) && mem.mem_wready && (mask_rem == 9'b0));
    end

    // Main sequencer: state, cell walk, direction mask and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cell_x      <= '0;
            cell_y      <= '0;
            cur_dir     <= '0;
            mask        <= '0;
            write_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cell_x      <= '0;
                        cell_y      <= '0;
                        write_count <= '0;
                        busy        <= 1'b1;
                        state       <= WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (f_in_valid) begin
                        mask <= mask_in;
                        if (mask_in != 9'b0) begin
                            cur_dir <= lowest_set(mask_in);
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (mem.mem_wready) begin
                        mask <= mask_rem;
                        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
                        if (mask_rem != 9'b0) cur_dir <= lowest_set(mask_rem);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // The final cell keeps its coordinate so the pass result stays readable.
            if (cell_done) begin
                if (last_cell) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    if (cell_x == LAST_POS) begin
                        cell_x <= '0;
                        cell_y <= cell_y + ADDRESS_WIDTH'(1);
                    end else begin
                        cell_x <= cell_x + ADDRESS_WIDTH'(1);
                    end
                    state <= WAIT_IN;
                end
            end
        end
    end

    // Cell data capture at the f_in handshake; pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (state == WAIT_IN && f_in_valid) begin
            for (int i = 0; i < 9; i++) begin
                f_q[i]    <= f_in[(8-i)*DATA_WIDTH +: DATA_WIDTH];
                addr_q[i] <= stream_addr[(8-i)*ADDRESS_WIDTH +: ADDRESS_WIDTH-1];
            end
        end
    end

    // Handshake and write-port outputs decoded from registered state only.
    always_comb begin
        f_in_ready    = (state == WAIT_IN);
        mem.mem_we    = (state == WRITE);
        mem.mem_wsel  = '0;
        mem.mem_waddr = '0;
        mem.mem_wdata = '0;
        if (state == WRITE) begin
            mem.mem_wsel  = cur_dir;
            mem.mem_waddr = addr_q[cur_dir];
            mem.mem_wdata = f_q[cur_dir];
        end
    end

endmodule

// File: tb/tb_stream_write_scheduler.sv
// Bench for stream_write_scheduler: a D2Q9 streaming-unit model and a
// collision-stage model drive the DUT; each handshake pushes the expected
// writes of that cell, and a negedge monitor pops them as writes are accepted.
module tb_stream_write_scheduler;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int SIDE = 16;

    localparam int CX [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    localparam int CY [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

    typedef struct packed {
        logic [7:0]  a;
        logic [3:0]  s;
        logic [15:0] d;
    } wr_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   cell_x;
    logic [AW-1:0]   cell_y;
    logic [9*AW-1:0] stream_addr;
    logic [9*DW-1:0] f_in;
    logic            f_in_valid;
    logic            f_in_ready;
    logic [15:0]     write_count;

    stream_write_scheduler_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    stream_write_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .stream_addr (stream_addr),
        .f_in        (f_in),
        .f_in_valid  (f_in_valid),
        .f_in_ready  (f_in_ready),
        .mem         (mem_bus.master),
        .write_count (write_count)
    );

    int checks = 0;
    int errors = 0;

    wr_t exp_q [$];
    int  ex, ey, exp_total;
    int  busy_cycles, done_pulses, handshakes;
    logic        prev_stall;
    logic [27:0] prev_bus;
    logic        bp_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] data_for(input int x, input int y, input int i);
        if (x == 5 && y == 5) return 16'h0100 + 16'(i);
        return 16'h8000 | 16'(x << 8) | 16'(y << 4) | 16'(i);
    endfunction

    // Streaming unit and collision stage models attached to the DUT's cell coordinate.
    always_comb begin
        int nx, ny;
        stream_addr = '0;
        f_in = '0;
        for (int i = 0; i < 9; i++) begin
            nx = int'(cell_x) + CX[i];
            ny = int'(cell_y) + CY[i];
            if (nx < 0 || nx >= SIDE || ny < 0 || ny >= SIDE)
                stream_addr[(8-i)*AW +: AW] = {1'b1, 8'h00};
            else
                stream_addr[(8-i)*AW +: AW] = {1'b0, 8'(ny*SIDE + nx)};
            f_in[(8-i)*DW +: DW] = data_for(int'(cell_x), int'(cell_y), i);
        end
    end

    // Memory-ready driver: always ready, or a 1,0,0,1 pattern under backpressure.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        mem_bus.mem_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                mem_bus.mem_wready = pat[k % 4];
                k++;
            end else begin
                mem_bus.mem_wready = 1'b1;
            end
        end
    end

    // Monitor: expected writes per handshake, scoreboard pops, stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            ex = 0; ey = 0; exp_total = 0;
            prev_stall = 1'b0;
        end else begin
            if (!busy && start) begin
                exp_q.delete();
                ex = 0; ey = 0; exp_total = 0;
                busy_cycles = 0; done_pulses = 0; handshakes = 0;
            end else begin
                if (busy) busy_cycles++;
                if (done) done_pulses++;
            end

            if (prev_stall) begin
                check("hold_we", 32'(mem_bus.mem_we), 32'd1);
                check("hold_bus", 32'({mem_bus.mem_waddr, mem_bus.mem_wsel, mem_bus.mem_wdata}),
                      32'(prev_bus));
            end
            prev_stall = mem_bus.mem_we && !mem_bus.mem_wready;
            prev_bus   = {mem_bus.mem_waddr, mem_bus.mem_wsel, mem_bus.mem_wdata};

            if (f_in_ready && f_in_valid) begin
                wr_t w;
                int nx, ny;
                check("cell_xy", 32'({cell_x, cell_y}), 32'({9'(ex), 9'(ey)}));
                check("count_at_cell", 32'(write_count), 32'(exp_total));
                check("cell_writes_drained", 32'(exp_q.size()), 32'd0);
                for (int i = 0; i < 9; i++) begin
                    nx = ex + CX[i];
                    ny = ey + CY[i];
                    if (nx >= 0 && nx < SIDE && ny >= 0 && ny < SIDE) begin
                        w.a = 8'(ny*SIDE + nx);
                        w.s = 4'(i);
                        w.d = data_for(ex, ey, i);
                        exp_q.push_back(w);
                        exp_total++;
                    end
                end
                handshakes++;
                ex++;
                if (ex == SIDE) begin
                    ex = 0;
                    ey++;
                end
            end

            if (mem_bus.mem_we && mem_bus.mem_wready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'({mem_bus.mem_waddr, mem_bus.mem_wsel}), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write", 32'({mem_bus.mem_waddr, mem_bus.mem_wsel, mem_bus.mem_wdata}),
                          32'(e));
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_f_in_ready"}, 32'(f_in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_bus.mem_we), 32'd0);
        check({tag, "_mem_bus"}, 32'({mem_bus.mem_waddr, mem_bus.mem_wsel, mem_bus.mem_wdata}), 32'd0);
        check({tag, "_write_count"}, 32'(write_count), 32'd0);
        check({tag, "_cell"}, 32'({cell_x, cell_y}), 32'd0);
    endtask

    initial begin
        int bb;
        bit seen_we;
        rst_n = 1'b0;
        start = 1'b0;
        f_in_valid = 1'b1;
        bp_mode = 1'b0;
        busy_cycles = 0; done_pulses = 0; handshakes = 0;

        #1;
        check_idle_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a write burst.
        pulse_start();
        seen_we = 0;
        for (int c = 0; c < 50 && !seen_we; c++) begin
            @(negedge clk);
            if (mem_bus.mem_we) seen_we = 1;
        end
        check("reach_write", 32'(seen_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        bb = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) bb++;
        end
        check("idle_after_reset", 32'(bb), 32'd0);

        // Full sweep, always ready, with a stray start mid-pass.
        pulse_start();
        repeat (500) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(20000);
        check("sweep_write_count", 32'(write_count), 32'd2116);
        check("sweep_handshakes", 32'(handshakes), 32'd256);
        check("sweep_done_pulses", 32'(done_pulses), 32'd1);
        check("sweep_busy_cycles", 32'(busy_cycles), 32'd2373);
        check("sweep_busy_fallen", 32'(busy), 32'd0);
        check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full sweep with memory backpressure.
        bp_mode = 1'b1;
        pulse_start();
        wait_done(20000);
        check("bp_write_count", 32'(write_count), 32'd2116);
        check("bp_handshakes", 32'(handshakes), 32'd256);
        check("bp_done_pulses", 32'(done_pulses), 32'd1);
        check("bp_busy_fallen", 32'(busy), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_write_scheduler.md
# stream_write_scheduler

Sequences one streaming pass of the D2Q9 lattice: walks every cell in raster order, drives the cell coordinate to the streaming address unit, and accepts the cell's nine post-collision distributions from the collision stage. It then serialises the in-range distributions into single-port writes toward the destination memory. Out-of-range (boundary) directions are skipped, not written. It sits between the collision datapath and the distribution RAM write port.

## Interface
- GRID_DIM, 256, total lattice cells.
- SIDE_LENGTH, GRID_DIM/16, cells per row/column.
- ADDRESS_WIDTH, $clog2(GRID_DIM)+1, per-direction address field width; MSB set means invalid.
- DATA_WIDTH, 16, width of one distribution value.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse after the last write of the pass.
- cell_x  out  ADDRESS_WIDTH  current cell x, zero-extended, to the streaming unit.
- cell_y  out  ADDRESS_WIDTH  current cell y, zero-extended.
- stream_addr  in  9*ADDRESS_WIDTH  destination addresses for cell_x/cell_y. Combinational return. Direction i is in bits [(9-i)*ADDRESS_WIDTH-1 : (8-i)*ADDRESS_WIDTH].
- f_in  in  9*DATA_WIDTH  distributions for the current cell, same packing (direction 0 most significant).
- f_in_valid  in  1  f_in holds the current cell's data.
- f_in_ready  out  1  scheduler can accept f_in.
- mem_we  out  1  write request.
- mem_wready  in  1  memory accepts the write this cycle.
- mem_waddr  out  ADDRESS_WIDTH-1  destination cell address (field LSBs).
- mem_wsel  out  4  direction index 0..8, which selects the distribution plane.
- mem_wdata  out  DATA_WIDTH  distribution value.
- write_count  out  16  writes accepted in the current or last pass.

## Operation
- States: IDLE, WAIT_IN, WRITE, DONE.
- **IDLE**
  - On start: clear cell_x, cell_y and write_count, then go to WAIT_IN.
  - start in any other state is ignored.
- **WAIT_IN**
  - f_in_ready = 1.
  - On f_in_valid, in the same cycle:
    - latch f_in;
    - latch valid_mask[i] = ~stream_addr field i MSB;
    - latch the address field LSBs for all nine directions.
  - If the latched mask is non-zero, go to WRITE with cur_dir = the lowest set index.
  - If the mask is zero, the cell completes immediately with no writes (see cell advance).
- **WRITE**
  - mem_we = 1, mem_wsel = cur_dir, mem_waddr = latched address[cur_dir], mem_wdata = latched f[cur_dir].
  - On mem_wready:
    - clear mask bit cur_dir and increment write_count;
    - set cur_dir to the next lowest set bit.
  - If the mask becomes empty, the cell completes.
  - With mem_wready low, hold all outputs stable.
- **Cell advance on completion**
  - x increments; on x = SIDE_LENGTH-1, x wraps to 0 and y increments.
  - If the completed cell was (SIDE_LENGTH-1, SIDE_LENGTH-1), go to DONE. Otherwise go to WAIT_IN.
- **DONE**
  - done = 1 for one cycle, then go to IDLE.
  - cell_x/cell_y and write_count hold their final values.
- Reset (any time, including mid-pass):
  - state IDLE; cell_x, cell_y, cur_dir, mask and write_count = 0.
  - busy, done, f_in_ready and mem_we = 0.
  - A partial pass is abandoned; no resume.
- write_count saturates at 16'hFFFF.

## Timing
- Cycle 0: start is sampled in IDLE. Cycle 1: WAIT_IN, busy = 1.
- Per cell:
  - 1 handshake cycle (with f_in_valid high), then N_valid write cycles with mem_wready held high.
  - Zero-write cells take 1 cycle.
- Writes within a cell are issued in ascending direction index; there are no gaps while mem_wready is high.
- The first write of a cell appears the cycle after its f_in handshake.
- The cycle after a cell's last accepted write is WAIT_IN for the next cell, or DONE.
- cell_x/cell_y change only on cell completion and are stable throughout WAIT_IN; stream_addr is sampled at the handshake.
- mem_* outputs and f_in_ready are decoded from registered state only. mem_wready has no combinational path to them.

## Test plan
- **Reset:** assert rst_n = 0 mid-WRITE → all outputs are 0 immediately. After release with no start, busy stays 0.
- **Interior cell:** D2Q9 streaming unit attached, velocity order (0,0),(1,0),(0,1),(-1,0),(0,-1),(1,1),(-1,1),(-1,-1),(1,-1), cell (5,5), f_i = 16'h0100+i → 9 consecutive writes, mem_wsel 0..8, mem_wdata 0x0100..0x0108.
- **Corner:** cell (0,0) → exactly 4 writes, mem_wsel 0,1,2,5. The next cell is (1,0) at the following WAIT_IN.
- **Backpressure:** toggle mem_wready 1,0,0,1… on an interior cell → each write is held stable while mem_wready is low. Still 9 writes, and write_count rises by 9.
- **Full sweep:** 16x16 grid, f_in_valid and mem_wready tied high → write_count = 2116, done pulses once after 256 handshakes + 2116 writes, then busy falls.
- **start while busy:** pulse start mid-pass → no restart; counts match the full-sweep values.
